// File: rtl/status_tx_pkg.sv
// Shared types and constants for the status display transmitter:
// FSM state encoding and the active-low 7-segment glyph table.
package status_tx_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    LATCH = 2'd2
  } state_t;

  // Index n gives the {dp,g,f,e,d,c,b,a} byte for hex digit n.
  localparam logic [15:0][7:0] SEG7 = {
    8'h8E, 8'h86, 8'hA1, 8'hC6,
    8'h83, 8'h88, 8'h90, 8'h80,
    8'hF8, 8'h82, 8'h92, 8'h99,
    8'hB0, 8'hA4, 8'hF9, 8'hC0
  };

endpackage

// File: rtl/hex_to_seg7.sv
// Hex digit to active-low 7-segment byte, dp always off.
// Ports: hex (4-bit digit in), seg ({dp,g,f,e,d,c,b,a} out).
module hex_to_seg7
  import status_tx_pkg::*;
(
  input  logic [3:0] hex,
  output logic [7:0] seg
);

  assign seg = SEG7[hex];

endmodule

// File: rtl/status_tx.sv
// Serial transmitter: encodes the nibble status word to 7-seg bytes
// and shifts it MSB-first into a 74HC595-style chain, then latches.
// Ports: clk, rst (sync, active-high), data (packed nibbles),
// start (send request), busy, done (1-cycle pulse),
// ser_clk, ser_dout, ser_latch (display chain).
module status_tx
  import status_tx_pkg::*;
#(
  parameter int NIBBLES = 10,
  parameter int CLK_DIV = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [4*NIBBLES-1:0]   data,
  input  logic                   start,
  output logic                   busy,
  output logic                   done,
  output logic                   ser_clk,
  output logic                   ser_dout,
  output logic                   ser_latch
);

  localparam int BITS = 8 * NIBBLES;
  localparam int DW   = $clog2(2 * CLK_DIV);
  localparam int BW   = $clog2(BITS);

  localparam logic [DW-1:0] DIV_LAST = DW'(2 * CLK_DIV - 1);
  localparam logic [DW-1:0] DIV_HALF = DW'(CLK_DIV);
  localparam logic [DW-1:0] LAT_LAST = DW'(CLK_DIV - 1);
  localparam logic [DW-1:0] DIV_ONE  = DW'(1);
  localparam logic [BW-1:0] BIT_LAST = BW'(BITS - 1);
  localparam logic [BW-1:0] BIT_ONE  = BW'(1);

  state_t            state, state_n;
  logic [BITS-1:0]   sreg, sreg_n;
  logic [BITS-1:0]   enc;
  logic [DW-1:0]     div, div_n;
  logic [BW-1:0]     bitc, bitc_n;
  logic              pending, pend_n;
  logic              done_q, done_n;

  // Digit NIBBLES-1 lands in the top byte so it leaves first.
  for (genvar i = 0; i < NIBBLES; i++) begin : g_enc
    hex_to_seg7 u_seg (
      .hex (data[4*i +: 4]),
      .seg (enc[8*i +: 8])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      sreg    <= '0;
      div     <= '0;
      bitc    <= '0;
      pending <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state   <= state_n;
      sreg    <= sreg_n;
      div     <= div_n;
      bitc    <= bitc_n;
      pending <= pend_n;
      done_q  <= done_n;
    end
  end

  always_comb begin
    state_n = state;
    sreg_n  = sreg;
    div_n   = div;
    bitc_n  = bitc;
    pend_n  = pending;
    done_n  = 1'b0;
    unique case (state)
      IDLE: begin
        if (start | pending) begin
          sreg_n  = enc;
          pend_n  = 1'b0;
          div_n   = '0;
          bitc_n  = '0;
          state_n = SHIFT;
        end
      end
      SHIFT: begin
        if (start) pend_n = 1'b1;
        if (div == DIV_LAST) begin
          // Shift on the falling ser_clk edge: data is
          // stable across the whole high phase.
          sreg_n = {sreg[BITS-2:0], 1'b0};
          div_n  = '0;
          bitc_n = bitc + BIT_ONE;
          if (bitc == BIT_LAST) state_n = LATCH;
        end else begin
          div_n = div + DIV_ONE;
        end
      end
      LATCH: begin
        if (start) pend_n = 1'b1;
        if (div == LAT_LAST) begin
          div_n   = '0;
          state_n = IDLE;
          done_n  = 1'b1;
        end else begin
          div_n = div + DIV_ONE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign busy      = (state != IDLE);
  assign done      = done_q;
  assign ser_clk   = (state == SHIFT) && (div >= DIV_HALF);
  assign ser_dout  = (state == SHIFT) && sreg[BITS-1];
  assign ser_latch = (state == LATCH);

endmodule

// File: tb/tb_status_tx.sv
// Self-checking bench for status_tx: small (2 nibble, div 2)
// and large (10 nibble, div 4) instances against a glyph model.
module tb_status_tx;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  data;
  logic        start;
  logic        busy, done, ser_clk, ser_dout, ser_latch;

  logic [39:0] data_b;
  logic        start_b;
  logic        busy_b, done_b, sclk_b, sdo_b, slat_b;

  always #5 clk = ~clk;

  status_tx #(.NIBBLES(2), .CLK_DIV(2)) dut (
    .clk(clk), .rst(rst), .data(data), .start(start),
    .busy(busy), .done(done), .ser_clk(ser_clk),
    .ser_dout(ser_dout), .ser_latch(ser_latch)
  );

  status_tx #(.NIBBLES(10), .CLK_DIV(4)) dut_b (
    .clk(clk), .rst(rst), .data(data_b), .start(start_b),
    .busy(busy_b), .done(done_b), .ser_clk(sclk_b),
    .ser_dout(sdo_b), .ser_latch(slat_b)
  );

  logic [7:0] glyph [16] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
    8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
  };

  function automatic logic [79:0] expect_stream(logic [39:0] d, int n);
    logic [79:0] r = '0;
    for (int i = n - 1; i >= 0; i--) r = {r[71:0], glyph[d[4*i +: 4]]};
    return r;
  endfunction

  typedef struct {
    logic [79:0] bits;
    int nb, blen, llen, st_cyc, done_cyc;
    bit done_ok;
  } frame_t;

  frame_t q[$];
  int n_pass = 0, n_tot = 0, rd = 0;
  int cyc = 0, act = 0, lat_total = 0;
  logic [79:0] acc;
  int nb, blen, llen, st_cyc;
  logic busy_q = 1'b0, sclk_q = 1'b0;

  always @(negedge clk) begin
    frame_t f;
    cyc++;
    if (busy === 1'b1 && !busy_q) begin
      acc = '0; nb = 0; blen = 0; llen = 0; st_cyc = cyc;
    end
    if (busy === 1'b1) blen++;
    if (ser_latch === 1'b1) begin llen++; lat_total++; end
    if (ser_clk === 1'b1 && !sclk_q) begin
      acc = {acc[78:0], ser_dout}; nb++;
    end
    if ((busy | done | ser_clk | ser_dout | ser_latch) === 1'b1) act++;
    if (done === 1'b1) begin
      f.bits = acc; f.nb = nb; f.blen = blen; f.llen = llen;
      f.st_cyc = st_cyc; f.done_cyc = cyc;
      f.done_ok = busy_q && (busy === 1'b0);
      q.push_back(f);
    end
    busy_q = (busy === 1'b1);
    sclk_q = (ser_clk === 1'b1);
  end

  logic [79:0] accb, fb_bits;
  int nbb, blenb, fb_nb, fb_blen, nd_b = 0;
  logic busyb_q = 1'b0, sclkb_q = 1'b0;

  always @(negedge clk) begin
    if (busy_b === 1'b1 && !busyb_q) begin
      accb = '0; nbb = 0; blenb = 0;
    end
    if (busy_b === 1'b1) blenb++;
    if (sclk_b === 1'b1 && !sclkb_q) begin
      accb = {accb[78:0], sdo_b}; nbb++;
    end
    if (done_b === 1'b1) begin
      fb_bits = accb; fb_nb = nbb; fb_blen = blenb; nd_b++;
    end
    busyb_q = (busy_b === 1'b1);
    sclkb_q = (sclk_b === 1'b1);
  end

  task automatic chk(string tag, logic [79:0] obs, logic [79:0] exp);
    n_tot++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic wait_frames(string tag, int n, int lim);
    int k = 0;
    while (q.size() < n && k < lim) begin
      @(posedge clk); k++;
    end
    chk({tag, "_frames"}, q.size(), n);
  endtask

  task automatic check_frame(string tag, logic [79:0] exp, output frame_t f);
    f = '{default: 0};
    if (q.size() > rd) begin
      f = q[rd];
      rd++;
    end
    chk({tag, "_bits"}, f.bits, exp);
    chk({tag, "_nbits"}, f.nb, 16);
    chk({tag, "_busy_len"}, f.blen, 66);
    chk({tag, "_latch_len"}, f.llen, 2);
    chk({tag, "_done_on_busy_fall"}, f.done_ok, 1);
  endtask

  initial begin
    frame_t fa, fb;
    logic [7:0] d1, d2;
    int a0, qs, lt;

    rst = 1'b1; start = 1'b0; data = '0;
    start_b = 1'b0; data_b = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_outputs",
        {busy, done, ser_clk, ser_dout, ser_latch}, 5'b0);
    a0 = act;
    repeat (20) @(posedge clk);
    @(negedge clk);
    chk("idle_activity", act - a0, 0);

    data = 8'h10;
    pulse_start();
    wait_frames("f10", rd + 1, 200);
    check_frame("f10", expect_stream(40'h10, 2), fa);

    data = 8'h8F;
    pulse_start();
    repeat (20) @(posedge clk);
    data = 8'h00;
    wait_frames("f8f", rd + 1, 200);
    check_frame("f8f", expect_stream(40'h8F, 2), fa);

    for (int it = 0; it < 4; it++) begin
      d1 = (it == 0) ? 8'h10 : 8'($urandom);
      d2 = (it == 0) ? 8'h23 : 8'($urandom);
      data = d1;
      pulse_start();
      repeat (28) @(posedge clk);
      pulse_start();
      data = d2;
      repeat (8) @(posedge clk);
      pulse_start();
      wait_frames("pend", rd + 2, 400);
      check_frame("pend_a", expect_stream({32'h0, d1}, 2), fa);
      check_frame("pend_b", expect_stream({32'h0, d2}, 2), fb);
      chk("pend_gap", fb.st_cyc - fa.done_cyc, 1);
      repeat (150) @(posedge clk);
      chk("pend_single_depth", q.size(), rd);
    end

    d1 = 8'($urandom);
    data = d1;
    pulse_start();
    repeat (28) @(posedge clk);
    @(negedge clk);
    chk("abort_bits_before_rst", nb, 7);
    qs = q.size();
    lt = lat_total;
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("abort_outputs",
        {busy, done, ser_clk, ser_dout, ser_latch}, 5'b0);
    repeat (200) @(posedge clk);
    chk("abort_no_done", q.size(), qs);
    chk("abort_no_latch", lat_total, lt);
    d2 = 8'($urandom);
    data = d2;
    pulse_start();
    wait_frames("after_abort", rd + 1, 200);
    check_frame("after_abort", expect_stream({32'h0, d2}, 2), fa);

    data_b = 40'h1111111111;
    @(posedge clk); #1 start_b = 1'b1;
    @(posedge clk); #1 start_b = 1'b0;
    begin
      int k = 0;
      while (nd_b < 1 && k < 1500) begin
        @(posedge clk); k++;
      end
    end
    chk("big_done", nd_b, 1);
    chk("big_bits", fb_bits, expect_stream(40'h1111111111, 10));
    chk("big_nbits", fb_nb, 80);
    chk("big_busy_len", fb_blen, 644);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
